// File: rtl/mult8x8_seq.sv
// Sequencer that forms an 8x8 unsigned product over four cycles
// using one shared external 4x4 multiplier.
// Optional seven-segment state display: define MULT8X8_SEQ_SEG_EN.
module mult8x8_seq #(
  parameter bit DONE_PULSE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [3:0]  mult_a,
  output logic [3:0]  mult_b,
  input  logic [7:0]  mult_p,
  output logic [15:0] product8x8_out,
  output logic        done_flag,
  output logic        busy
`ifdef MULT8X8_SEQ_SEG_EN
  ,
  output logic [6:0]  seg_out
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  count;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [15:0] acc;
  logic [15:0] partial;
  logic        accept;

  assign accept = start && (state == IDLE || state == DONE);
  assign product8x8_out = acc;

  // State register
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (count == 2'd3) state_nxt = DONE;
      DONE: begin
        if (start)           state_nxt = CALC;
        else if (DONE_PULSE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial product aligned to its nibble weight
  always_comb begin
    partial = {8'h00, mult_p};
    unique case (count)
      2'd0: partial = {8'h00, mult_p};
      2'd1,
      2'd2: partial = {4'h0, mult_p, 4'h0};
      2'd3: partial = {mult_p, 8'h00};
      default: partial = {8'h00, mult_p};
    endcase
  end

  // Operand latch, step counter and accumulator
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
      acc   <= 16'h0000;
      count <= 2'd0;
    end else if (accept) begin
      a_reg <= dataa;
      b_reg <= datab;
      acc   <= 16'h0000;
      count <= 2'd0;
    end else if (state == CALC) begin
      acc   <= acc + partial;
      count <= count + 2'd1;
    end
  end

  // Multiplier operands and status outputs
  always_comb begin
    mult_a    = 4'h0;
    mult_b    = 4'h0;
    busy      = (state == CALC);
    done_flag = (state == DONE);
    if (state == CALC) begin
      mult_a = count[0] ? a_reg[7:4] : a_reg[3:0];
      mult_b = count[1] ? b_reg[7:4] : b_reg[3:0];
    end
  end

`ifdef MULT8X8_SEQ_SEG_EN
  // Seven-segment digit for current state, {g,f,e,d,c,b,a}
  always_comb begin
    seg_out = 7'b0111111;
    unique case (state)
      IDLE: seg_out = 7'b0111111;
      CALC: begin
        unique case (count)
          2'd0: seg_out = 7'b0000110;
          2'd1: seg_out = 7'b1011011;
          2'd2: seg_out = 7'b1001111;
          2'd3: seg_out = 7'b1100110;
          default: seg_out = 7'b0111111;
        endcase
      end
      DONE: seg_out = 7'b1011110;
      default: seg_out = 7'b0111111;
    endcase
  end
`endif

endmodule

// File: tb/tb_mult8x8_seq.sv
// Directed bench for mult8x8_seq, hold (DONE_PULSE=0) and
// pulse (DONE_PULSE=1) variants side by side.
module tb_mult8x8_seq;

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [3:0]  ma0, mb0, ma1, mb1;
  logic [7:0]  mp0, mp1;
  logic [15:0] prod0, prod1;
  logic        done0, done1;
  logic        busy0, busy1;
`ifdef MULT8X8_SEQ_SEG_EN
  logic [6:0]  seg0, seg1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  assign mp0 = ma0 * mb0;
  assign mp1 = ma1 * mb1;

  mult8x8_seq #(.DONE_PULSE(1'b0)) dut0 (
    .clk(clk), .reset_a(reset_a), .start(start),
    .dataa(dataa), .datab(datab),
    .mult_a(ma0), .mult_b(mb0), .mult_p(mp0),
    .product8x8_out(prod0), .done_flag(done0), .busy(busy0)
`ifdef MULT8X8_SEQ_SEG_EN
    , .seg_out(seg0)
`endif
  );

  mult8x8_seq #(.DONE_PULSE(1'b1)) dut1 (
    .clk(clk), .reset_a(reset_a), .start(start),
    .dataa(dataa), .datab(datab),
    .mult_a(ma1), .mult_b(mb1), .mult_p(mp1),
    .product8x8_out(prod1), .done_flag(done1), .busy(busy1)
`ifdef MULT8X8_SEQ_SEG_EN
    , .seg_out(seg1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an operation; caller is left just after the accepting edge
  task automatic go(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    dataa = a;
    datab = b;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    go(a, b);
    repeat (4) tick();
    chk({tag, "_prod"}, prod0, exp);
    chk({tag, "_done"}, done0, 1);
  endtask

  int dcnt;

  initial begin
    reset_a = 1'b1;
    start   = 1'b0;
    dataa   = 8'h00;
    datab   = 8'h00;
    #12;
    chk("rst_prod", prod0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_mab", {ma0, mb0}, 0);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_idle", seg0, 7'b0111111);
`endif
    @(negedge clk);
    reset_a = 1'b0;
    tick();

    // Test 1: nibble schedule for 0x12 x 0x34
    go(8'h12, 8'h34);
    chk("t1_c0", {ma0, mb0}, 8'h24);
    chk("t1_busy", busy0, 1);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_c0", seg0, 7'b0000110);
`endif
    tick();
    chk("t1_c1", {ma0, mb0}, 8'h14);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_c1", seg0, 7'b1011011);
`endif
    tick();
    chk("t1_c2", {ma0, mb0}, 8'h23);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_c2", seg0, 7'b1001111);
`endif
    tick();
    chk("t1_c3", {ma0, mb0}, 8'h13);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_c3", seg0, 7'b1100110);
`endif
    tick();
    chk("t1_prod", prod0, 16'h03A8);
    chk("t1_done", done0, 1);
    chk("t1_busy", busy0, 0);
    chk("t1_mab", {ma0, mb0}, 0);
    chk("t1_prod1", prod1, 16'h03A8);
    chk("t1_done1", done1, 1);
`ifdef MULT8X8_SEQ_SEG_EN
    chk("seg_done", seg0, 7'b1011110);
`endif
    tick();
    chk("t1_pulse_off", done1, 0);
    chk("t1_pulse_idle", busy1, 0);
    chk("t1_pulse_hold", prod1, 16'h03A8);
    chk("t1_hold_done", done0, 1);

    // Test 2: extremes
    run("t2_ff", 8'hFF, 8'hFF, 16'hFE01);
    run("t2_zero", 8'h00, 8'hA5, 16'h0000);
    run("t2_mix", 8'hA5, 8'h3C, 16'h26AC);

    // Test 3: start and operand changes mid-op ignored
    dcnt = 0;
    go(8'h12, 8'h34);
    dcnt += done1;
    tick();
    dcnt += done1;
    start = 1'b1;
    dataa = 8'h99;
    datab = 8'h99;
    tick();
    dcnt += done1;
    start = 1'b0;
    dataa = 8'h55;
    chk("t3_c2", {ma0, mb0}, 8'h23);
    tick();
    dcnt += done1;
    tick();
    dcnt += done1;
    chk("t3_prod", prod0, 16'h03A8);
    chk("t3_prod1", prod1, 16'h03A8);
    repeat (3) begin
      tick();
      dcnt += done1;
    end
    chk("t3_one_done", dcnt, 1);

    // Test 4: async reset mid-calculation
    go(8'hFF, 8'hFF);
    tick();
    tick();
    #2;
    reset_a = 1'b1;
    #1;
    chk("t4_prod", prod0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_mab", {ma0, mb0}, 0);
    chk("t4_done", done0, 0);
    #1;
    reset_a = 1'b0;
    tick();
    chk("t4_idle", busy0, 0);
    run("t4_after", 8'h0F, 8'h10, 16'h00F0);

    // Test 5: done held across idle cycles
    dcnt = 0;
    repeat (10) begin
      tick();
      dcnt += done0;
    end
    chk("t5_hold", dcnt, 10);
    chk("t5_hold_prod", prod0, 16'h00F0);

    // Back-to-back with start held high
    start = 1'b1;
    dataa = 8'h12;
    datab = 8'h34;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t5_b2b_busy", busy0, 1);
      repeat (4) tick();
      chk("t5_b2b_prod", prod0, 16'h03A8);
      chk("t5_b2b_done", done0, 1);
      chk("t5_b2b_done1", done1, 1);
      tick();
    end
    start = 1'b0;
    repeat (5) tick();
    chk("t5_end_done1", done1, 0);
    chk("t5_end_done0", done0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
